// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: jump opcodes, instruction
// field positions and the packed {pc, ir} entry held in the skid buffer.
package fetch_unit_pkg;

  localparam logic [4:0]  OPC_J       = 5'b00001;
  localparam logic [4:0]  OPC_JAL     = 5'b00011;
  localparam int          OPC_MSB     = 31;
  localparam int          OPC_LSB     = 27;
  localparam int          JTARGET_MSB = 26;
  localparam int          JTARGET_LSB = 0;
  localparam logic [31:0] NOP_DEFAULT = 32'd0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  function automatic logic is_jump(input logic [31:0] ir);
    return (ir[OPC_MSB:OPC_LSB] == OPC_J) || (ir[OPC_MSB:OPC_LSB] == OPC_JAL);
  endfunction

  // Jump targets are absolute word addresses with the upper five bits cleared.
  function automatic logic [31:0] jump_target(input logic [31:0] ir);
    return {5'b0, ir[JTARGET_MSB:JTARGET_LSB]};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Small circular FIFO of fetched {pc, ir} entries between imem and the FD latch.
// Flush empties it in one cycle; the head entry is visible combinationally.
module fetch_skid_buffer
  import fetch_unit_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  localparam int CNT_W = $clog2(BUF_DEPTH + 1),
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head_entry,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  fetch_entry_t     mem [BUF_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty      = (count == '0);
  assign head_entry = mem[head];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[tail] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem requests, captures the
// one-cycle-latency responses into the skid buffer and decodes J/JAL early.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] NOP_WORD  = NOP_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  output logic        imem_req,
  input  logic [31:0] q_imem,
  input  logic        fd_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] fd_pc_out,
  output logic [31:0] fd_ir_out,
  output logic        fd_valid,
  output logic [31:0] fetch_count
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [31:0]      pc;
  logic [31:0]      pc_next;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic [31:0]      last_pc;
  logic [31:0]      jtgt;
  logic [CNT_W-1:0] count;
  logic             buf_empty;
  logic             pop;
  logic             resp;
  logic             jump;
  logic             has_space;
  logic             issue;
  fetch_entry_t     head_entry;
  fetch_entry_t     push_entry;

  assign fd_valid = ~buf_empty;
  assign pop      = fd_valid & ~fd_stall;

  // Free slots = depth - buffered - in flight + popped; issue needs at least one.
  assign has_space = (32'(count) + 32'(inflight) + 32'd1) <= (32'(BUF_DEPTH) + 32'(pop));
  assign issue     = ~redirect_valid & has_space;
  assign imem_req  = issue & ~reset;

  assign resp = inflight & ~redirect_valid;
  assign jump = resp & is_jump(q_imem);
  assign jtgt = jump_target(q_imem);

  assign push_entry = '{pc: inflight_pc, ir: q_imem};

  always_comb begin
    address_imem = pc;
    if (redirect_valid) address_imem = redirect_target;
    else if (jump)      address_imem = jtgt;
  end

  // A jump decoded while issue is blocked stays in pc until it can be fetched.
  always_comb begin
    pc_next = address_imem;
    if (redirect_valid) pc_next = redirect_target;
    else if (issue)     pc_next = address_imem + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fetch_count <= '0;
      last_pc     <= '0;
    end else begin
      pc          <= pc_next;
      inflight    <= issue;
      inflight_pc <= address_imem;
      if (resp)     fetch_count <= fetch_count + 32'd1;
      if (fd_valid) last_pc     <= head_entry.pc;
    end
  end

  assign fd_pc_out = fd_valid ? head_entry.pc : last_pc;
  assign fd_ir_out = fd_valid ? head_entry.ir : NOP_WORD;

  fetch_skid_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_skid_buffer (
    .clock      (clock),
    .reset      (reset),
    .push       (resp),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_entry (head_entry),
    .count      (count),
    .empty      (buf_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an imem model, an architectural
// instruction-stream scoreboard and cycle-exact checks for jumps and redirects.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'd0;
  localparam logic [31:0] JUNK  = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_imem;
  logic        imem_req;
  logic [31:0] q_imem;
  logic        fd_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] fd_pc_out;
  logic [31:0] fd_ir_out;
  logic        fd_valid;
  logic [31:0] fetch_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ[$];
  logic [31:0] streamPc;
  logic        prevReq;
  logic [31:0] prevAddr;
  int          occ;
  int          pushCount;

  always #5 clock = ~clock;

  fetch_unit #(
    .BUF_DEPTH (DEPTH),
    .RESET_PC  (32'd0),
    .NOP_WORD  (NOP)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .address_imem    (address_imem),
    .imem_req        (imem_req),
    .q_imem          (q_imem),
    .fd_stall        (fd_stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fd_pc_out       (fd_pc_out),
    .fd_ir_out       (fd_ir_out),
    .fd_valid        (fd_valid),
    .fetch_count     (fetch_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Program image: plain ALU words everywhere except a few jumps.
  function automatic logic [31:0] imemWord(input logic [31:0] a);
    case (a)
      32'h005: return {5'b00001, 27'h040};
      32'h103: return {5'b00011, 27'h200};
      32'h203: return {5'b00001, 27'h300};
      default: return {5'b00101, a[26:0]};
    endcase
  endfunction

  function automatic logic [31:0] nextPc(input logic [31:0] a);
    logic [31:0] w;
    w = imemWord(a);
    if (w[31:27] == 5'b00001 || w[31:27] == 5'b00011) return {5'b0, w[26:0]};
    return a + 32'd1;
  endfunction

  task automatic refill();
    while (expQ.size() < 4) begin
      expQ.push_back(streamPc);
      streamPc = nextPc(streamPc);
    end
  endtask

  task automatic restartStream(input logic [31:0] startPc);
    expQ.delete();
    streamPc = startPc;
    refill();
  endtask

  task automatic resetModel();
    restartStream(32'd0);
    prevReq   = 1'b0;
    prevAddr  = '0;
    occ       = 0;
    pushCount = 0;
  endtask

  // Called just after a rising edge; drives one cycle and scoreboards it at the falling edge.
  task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] tgt);
    logic respNow;
    logic popNow;
    q_imem          = prevReq ? imemWord(prevAddr) : JUNK;
    fd_stall        = stall;
    redirect_valid  = redir;
    redirect_target = tgt;
    refill();
    @(negedge clock);
    respNow = prevReq & ~redir;
    popNow  = fd_valid & ~stall;
    checkOutput("fd_valid_occ", 32'(fd_valid), 32'(occ != 0));
    checkOutput("no_overflow", 32'(respNow && occ == DEPTH && !popNow), 32'd0);
    checkOutput("fetch_count", fetch_count, 32'(pushCount));
    if (!fd_valid) checkOutput("nop_when_empty", fd_ir_out, NOP);
    if (popNow) begin
      checkOutput("fd_pc", fd_pc_out, expQ[0]);
      checkOutput("fd_ir", fd_ir_out, imemWord(expQ[0]));
      void'(expQ.pop_front());
    end
    if (redir) restartStream(tgt);
    occ       = redir ? 0 : occ + int'(respNow) - int'(popNow);
    pushCount = pushCount + int'(respNow);
    prevReq   = imem_req;
    prevAddr  = address_imem;
  endtask

  initial begin
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    fd_stall        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    q_imem          = JUNK;
    resetModel();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (int c = 0; c < 33; c++) begin
      stall = (c >= 4 && c <= 6) || (c >= 19 && c <= 20) || (c == 25);
      redir = (c == 14) || (c == 25);
      tgt   = (c == 14) ? 32'h100 : 32'h180;
      applyStimulus(stall, redir, tgt);
      case (c)
        0: begin
          checkOutput("c0_req", 32'(imem_req), 32'd1);
          checkOutput("c0_addr", address_imem, 32'd0);
          checkOutput("c0_valid", 32'(fd_valid), 32'd0);
        end
        1: checkOutput("c1_addr", address_imem, 32'd1);
        2: begin
          checkOutput("c2_valid", 32'(fd_valid), 32'd1);
          checkOutput("c2_pc", fd_pc_out, 32'd0);
          checkOutput("c2_count", fetch_count, 32'd1);
        end
        3: checkOutput("c3_count", fetch_count, 32'd2);
        5, 6: begin
          checkOutput("stall_req", 32'(imem_req), 32'd0);
          checkOutput("stall_pc", fd_pc_out, 32'd2);
          checkOutput("stall_count", fetch_count, 32'd4);
        end
        9: begin
          checkOutput("j_addr", address_imem, 32'h40);
          checkOutput("j_req", 32'(imem_req), 32'd1);
        end
        11: checkOutput("j_head", fd_pc_out, 32'h40);
        14: checkOutput("redir_count_pre", fetch_count, 32'd10);
        15: begin
          checkOutput("redir_valid_r1", 32'(fd_valid), 32'd0);
          checkOutput("redir_count_r1", fetch_count, 32'd10);
          checkOutput("redir_addr_r1", address_imem, 32'h100);
          checkOutput("redir_hold_pc", fd_pc_out, 32'h43);
        end
        16: checkOutput("redir_valid_r2", 32'(fd_valid), 32'd0);
        17: begin
          checkOutput("redir_valid_r3", 32'(fd_valid), 32'd1);
          checkOutput("redir_pc_r3", fd_pc_out, 32'h100);
        end
        19, 20: begin
          checkOutput("jal_full_addr", address_imem, 32'h200);
          checkOutput("jal_full_req", 32'(imem_req), 32'd0);
        end
        21: begin
          checkOutput("jal_release_addr", address_imem, 32'h200);
          checkOutput("jal_release_req", 32'(imem_req), 32'd1);
        end
        25: begin
          checkOutput("redir_vs_j_addr", address_imem, 32'h180);
          checkOutput("redir_vs_j_req", 32'(imem_req), 32'd0);
        end
        26: begin
          checkOutput("redir_stall_flush", 32'(fd_valid), 32'd0);
          checkOutput("redir_vs_j_next", address_imem, 32'h180);
        end
        28: checkOutput("redir_vs_j_head", fd_pc_out, 32'h180);
        default: ;
      endcase
      @(posedge clock);
      #1;
    end

    #2 reset = 1'b1;
    #1;
    checkOutput("async_req", 32'(imem_req), 32'd0);
    checkOutput("async_valid", 32'(fd_valid), 32'd0);
    checkOutput("async_count", fetch_count, 32'd0);
    checkOutput("async_pc", fd_pc_out, 32'd0);
    checkOutput("async_ir", fd_ir_out, NOP);
    resetModel();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      if (c == 0) begin
        checkOutput("post_reset_addr", address_imem, 32'd0);
        checkOutput("post_reset_req", 32'(imem_req), 32'd1);
      end
      if (c == 2) checkOutput("post_reset_pc", fd_pc_out, 32'd0);
      @(posedge clock);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
